// File: rtl/pid_div_pkg.sv
// pid_div_pkg: shared widths, FSM encoding and helpers for the PID divide scheduler
package pid_div_pkg;
    localparam int OPW    = 16;
    localparam int INT_W  = 9;
    localparam int FRAC_W = 10;
    localparam int MW     = INT_W + FRAC_W;
    localparam int Y_W    = 1 + MW;
    localparam int QW     = OPW + 1 + FRAC_W;
    localparam int CW     = $clog2(QW);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_DONE} state_t;

    localparam logic [MW-1:0] MAG_SAT = '1;

    // 17-bit magnitude so that -32768 maps to +32768 without wrapping
    function automatic logic [OPW:0] mag_of(input logic [OPW-1:0] v);
        return v[OPW-1] ? (~{1'b1, v} + 1'b1) : {1'b0, v};
    endfunction
endpackage

// File: rtl/pid_div_scheduler_core.sv
// div_iter_core: multi-cycle signed restoring divider with sign-magnitude saturating result
//   clk, rst_n      : clock, async active-low reset
//   start, a, b     : accept signed operands (only honoured while idle)
//   done            : high during the cycle whose closing edge commits y/dbz/ovf
//   y, dbz, ovf     : registered result {sign, int, frac} and flags, held between results
//   busy            : registered, high whenever the FSM is not idle
module div_iter_core
    import pid_div_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic           done,
    output logic [Y_W-1:0] y,
    output logic           dbz,
    output logic           ovf,
    output logic           busy
);
    state_t         st;
    logic [OPW-1:0] a_r, b_r;
    logic [OPW:0]   magb, r, diff;
    logic [QW-1:0]  q;
    logic [CW-1:0]  cnt;
    logic           sign, zero;
    logic [OPW+1:0] rem_sh;
    logic           ge, ovf_w;
    logic [MW-1:0]  mag;

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        rem_sh = {r, q[QW-1]};
        ge     = rem_sh >= {1'b0, magb};
        diff   = rem_sh[OPW:0] - magb;
        ovf_w  = |q[QW-1:MW];
        mag    = zero ? '0 : (ovf_w ? MAG_SAT : q[MW-1:0]);
    end

    assign done = st == S_DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st   <= S_IDLE;
            busy <= 1'b0;
            a_r  <= '0;
            b_r  <= '0;
            magb <= '0;
            r    <= '0;
            q    <= '0;
            cnt  <= '0;
            sign <= 1'b0;
            zero <= 1'b0;
            y    <= '0;
            dbz  <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            case (st)
                S_IDLE: if (start) begin
                    a_r  <= a;
                    b_r  <= b;
                    busy <= 1'b1;
                    st   <= S_LOAD;
                end
                S_LOAD: begin
                    sign <= a_r[OPW-1] ^ b_r[OPW-1];
                    magb <= mag_of(b_r);
                    q    <= {mag_of(a_r), FRAC_W'(0)};
                    r    <= '0;
                    cnt  <= CW'(QW - 1);
                    zero <= b_r == '0;
                    st   <= (b_r == '0) ? S_DONE : S_CALC;
                end
                S_CALC: begin
                    r   <= ge ? diff : rem_sh[OPW:0];
                    q   <= {q[QW-2:0], ge};
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) st <= S_DONE;
                end
                default: begin
                    y    <= {sign & |mag, mag};
                    dbz  <= zero;
                    ovf  <= ovf_w & ~zero;
                    busy <= 1'b0;
                    st   <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: rtl/pid_div_scheduler.sv
// pid_div_scheduler: round-robin sharing of one iterative signed divider among NUM_REQ requesters
//   sys_clk, sys_rst_n     : clock, async active-low reset
//   req_valid/req_ready    : per-requester handshake, ready is one-hot to the winner while idle
//   req_a, req_b           : packed signed operands, requester i at [i*OPW +: OPW]
//   rsp_valid              : one-cycle registered pulse to the requester that owns the result
//   rsp_y, rsp_dbz, rsp_ovf: registered result and flags, held until the next response
//   busy                   : high whenever the divider is not idle
module pid_div_scheduler
    import pid_div_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*OPW-1:0] req_a,
    input  logic [NUM_REQ*OPW-1:0] req_b,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [Y_W-1:0]         rsp_y,
    output logic                   rsp_dbz,
    output logic                   rsp_ovf,
    output logic                   busy
);
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;

    logic [IW-1:0]      ptr, id, win;
    logic [NUM_REQ-1:0] grant;
    logic               start, done;
    int                 idx;

    // Scan from farthest to nearest so the first valid at/after ptr wins
    always_comb begin
        win = '0;
        idx = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (req_valid[idx]) win = IW'(idx);
        end
        grant     = |req_valid ? (NUM_REQ'(1) << win) : '0;
        req_ready = (sys_rst_n && !busy) ? grant : '0;
        start     = |(req_valid & req_ready);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ptr       <= '0;
            id        <= '0;
            rsp_valid <= '0;
        end else begin
            if (start) begin
                id  <= win;
                ptr <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
            end
            rsp_valid <= done ? (NUM_REQ'(1) << id) : '0;
        end
    end

    div_iter_core u_core (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .start (start),
        .a     (req_a[int'(win)*OPW +: OPW]),
        .b     (req_b[int'(win)*OPW +: OPW]),
        .done  (done),
        .y     (rsp_y),
        .dbz   (rsp_dbz),
        .ovf   (rsp_ovf),
        .busy  (busy)
    );
endmodule

// File: doc/pid_div_scheduler.md
Name: pid_div_scheduler

Overview:
- Time-shares one iterative signed-division engine between NUM_REQ requesters, e.g. PID channels computing error/scale ratios.
- Each request carries two signed 16-bit operands A and B.
- The result Y is returned in the team's 20-bit sign-magnitude fixed-point format: 1 sign bit, 9 integer bits, 10 fractional bits.
- Sits between the per-channel PID logic and the motor command path, replacing per-channel combinational dividers with one shared multi-cycle unit.

Parameters:
- NUM_REQ, 2, number of requesters; 2..8.
- OPW, 16, operand width, signed.
- INT_W, 9, integer bits of result magnitude.
- FRAC_W, 10, fractional bits of result magnitude.

Ports:
- sys_clk, in, 1, system clock.
- sys_rst_n, in, 1, asynchronous active-low reset.
- req_valid, in, NUM_REQ, per-requester request valid.
- req_ready, out, NUM_REQ, per-requester accept; one-hot or zero.
- req_a, in, NUM_REQ*OPW, packed dividends; requester i uses bits [i*OPW +: OPW].
- req_b, in, NUM_REQ*OPW, packed divisors, same packing.
- rsp_valid, out, NUM_REQ, one-cycle result pulse to the owning requester.
- rsp_y, out, 1+INT_W+FRAC_W, result {sign, int[8:0], frac[9:0]}.
- rsp_dbz, out, 1, divide-by-zero flag, valid with rsp_valid.
- rsp_ovf, out, 1, integer-overflow (saturated) flag, valid with rsp_valid.
- busy, out, 1, high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE; round-robin pointer = 0.
  - req_ready = 0 is combinational, so it is 0 whenever reset is active.
  - rsp_valid, rsp_y, rsp_dbz, rsp_ovf and busy are registered outputs, all 0 after reset.
  - Reset mid-operation discards the transaction; no rsp_valid is issued for it.
- Handshake:
  - A transfer occurs when req_valid[i] & req_ready[i] at a rising edge.
  - req_ready is combinational and asserted only in IDLE, only for the winner.
  - A requester holds req_valid and its operands stable until accepted.
  - req_ready never depends on rsp signals.
- Arbitration:
  - Round-robin starting at the pointer; the winner is the first i at or after the pointer with req_valid[i] set.
  - After a grant, pointer = (winner+1) mod NUM_REQ.
  - The pointer is unchanged when nothing is granted.
- FSM states: IDLE -> LOAD -> CALC -> DONE -> IDLE.
  - IDLE: on transfer, latch A, B and the winner id; go to LOAD.
  - LOAD:
    - sign = A[15]^B[15].
    - magA = |A| and magB = |B| as 17-bit unsigned, so -32768 maps to 32768 correctly.
    - If magB == 0, go to DONE with dbz.
    - Otherwise load the dividend magA<<FRAC_W (27 bits) and clear the partial remainder; go to CALC.
  - CALC: restoring division, one quotient bit per cycle, for exactly 27 cycles (counter 26 down to 0); then go to DONE.
  - DONE:
    - rsp_valid[id] = 1 for exactly one cycle.
    - rsp_y, rsp_dbz and rsp_ovf are registered in the same cycle; go to IDLE.
    - A new request may be accepted in the cycle after DONE.
- Latency: with the handshake edge as cycle 0, rsp_valid is high in cycle 29 for normal divides and in cycle 2 for divide-by-zero.
- Result rules:
  - The 27-bit quotient Q = floor(magA*1024 / magB), truncated toward zero.
  - If Q >= 2^19: magnitude saturates to all ones (int 511, frac 1023) and rsp_ovf = 1.
  - Divide-by-zero: rsp_y = 0, rsp_dbz = 1, rsp_ovf = 0.
  - When the magnitude is 0, the sign bit is forced to 0 (no negative zero).
- Between responses, rsp_y holds its last value; rsp_dbz and rsp_ovf also hold.
- Simultaneous requests are served one at a time in round-robin order.
- Requests arriving while busy wait with req_ready = 0.

Decomposition:
- Package pid_div_pkg holds:
  - OPW, INT_W, FRAC_W, Y_W = 1+INT_W+FRAC_W, QW = OPW+1+FRAC_W.
  - The FSM state encoding (IDLE/LOAD/CALC/DONE).
  - The saturated magnitude constant.
- One sub-module, div_iter_core:
  - Owns the magnitude/sign prep, restoring-division shift-subtract loop, cycle counter and saturation.
  - Interface: start/operands in, done/y/dbz/ovf out.
- pid_div_scheduler keeps the arbiter, pointer, id tracking and response demux.

Test Plan:
- Req0 A=100, B=7 -> rsp_valid[0] at cycle 29; rsp_y = {0, 9'd14, 10'd292}; dbz = 0, ovf = 0.
- Req1 A=-300, B=4 -> rsp_valid[1]; rsp_y = {1, 9'd75, 10'd0}. A=-1, B=4096 -> Q = 0, rsp_y = 0 with sign 0.
- Req0 A=5, B=0 -> rsp_valid[0] at cycle 2; rsp_y = 0, rsp_dbz = 1.
- Req0 A=-32768, B=1 -> rsp_ovf = 1; rsp_y = {1, 9'h1FF, 10'h3FF}. A=511, B=-1 -> {1, 9'd511, 10'd0}, ovf = 0.
- req_valid = 2'b11 held continuously from reset -> grants in order 0, 1, 0, 1; each rsp_valid is one-hot to the granted id; req_ready is 0 throughout busy.
- Assert sys_rst_n low in cycle 10 of CALC -> all outputs 0 immediately; no stale rsp_valid after release; next request completes normally.
